pi_ratio_div: RTL and testbench

PI_RATIO_DIV -- requirements
Module: pi_ratio_div

---
 rtl/pi_pkg.sv | 23 ++
 rtl/pi_div_step.sv | 23 ++
 rtl/pi_ratio_div.sv | 141 ++++++++++++++
 tb/tb_pi_ratio_div.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// Shared types and constants for the pi ratio divider.
// PI_DIV_ROUND_EN adds the ROUND state used for round-to-nearest.
package pi_pkg;

  localparam int unsigned FRAC_BITS_DEF = 8;
  localparam int unsigned CNT_W         = 16;

`ifdef PI_DIV_ROUND_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    ROUND = 2'd2,
    FIN   = 2'd3
  } pi_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd3
  } pi_state_e;
`endif

endpackage

// File: rtl/pi_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract when it fits.
module pi_div_step #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = DW + 1
) (
  input  logic [RW-1:0] rem_i,
  input  logic [DW-1:0] div_i,
  input  logic          bit_i,
  output logic [RW-1:0] rem_o,
  output logic          q_o
);

  logic [RW:0] shifted;
  logic [RW:0] div_ext;

  always_comb begin
    shifted = {rem_i, bit_i};
    div_ext = (RW+1)'(div_i);
    q_o     = (shifted >= div_ext);
    rem_o   = q_o ? RW'(shifted - div_ext) : RW'(shifted);
  end

endmodule

// File: rtl/pi_ratio_div.sv
// Pi estimate 4*inside/total by restoring division, one quotient bit per clock.
// Define PI_DIV_ROUND_EN to round to nearest (one extra cycle) instead of truncating.
module pi_ratio_div
  import pi_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     total_i,
  input  logic [CNT_W-1:0]     inside_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [FRAC_BITS+3:0] quot_o,
  output logic                 err_o
);

  localparam int unsigned QW = FRAC_BITS + 4;
  localparam int unsigned RW = CNT_W + 1;
  localparam int unsigned CW = $clog2(QW + 1);

  pi_state_e         state_q, state_d;
  logic [CNT_W-1:0]  tot_q, tot_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [QW-1:0]     dsr_q, dsr_d;
  logic [QW-1:0]     qsr_q, qsr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              errp_q, errp_d;
  logic [QW-1:0]     quot_q, quot_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [RW-1:0]     step_rem;
  logic              step_q;

  pi_div_step #(.DW(CNT_W), .RW(RW)) u_step (
    .rem_i (rem_q),
    .div_i (tot_q),
    .bit_i (dsr_q[QW-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tot_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      qsr_q   <= '0;
      cnt_q   <= '0;
      errp_q  <= 1'b0;
      quot_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      qsr_q   <= qsr_d;
      cnt_q   <= cnt_d;
      errp_q  <= errp_d;
      quot_q  <= quot_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tot_d   = tot_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    qsr_d   = qsr_q;
    cnt_d   = cnt_q;
    errp_d  = errp_q;
    quot_d  = quot_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((total_i == '0) || (inside_i > total_i)) begin
            qsr_d   = '1;
            errp_d  = 1'b1;
            state_d = FIN;
          end else begin
            // Numerator is inside<<(FRAC_BITS+2): its top part seeds the remainder.
            tot_d   = total_i;
            rem_d   = RW'(inside_i[CNT_W-1:2]);
            dsr_d   = {inside_i[1:0], {(QW-2){1'b0}}};
            qsr_d   = '0;
            cnt_d   = '0;
            errp_d  = 1'b0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d = step_rem;
        dsr_d = {dsr_q[QW-2:0], 1'b0};
        qsr_d = {qsr_q[QW-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) begin
`ifdef PI_DIV_ROUND_EN
          state_d = ROUND;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef PI_DIV_ROUND_EN
      ROUND: begin
        if (({rem_q, 1'b0} >= (RW+1)'(tot_q)) && (qsr_q != '1)) begin
          qsr_d = qsr_q + QW'(1);
        end
        state_d = FIN;
      end
`endif
      FIN: begin
        done_d  = 1'b1;
        quot_d  = qsr_q;
        err_d   = errp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_pi_ratio_div.sv
// Directed bench for pi_ratio_div with a queue of expected results.
module tb_pi_ratio_div;

  localparam int unsigned FB = 8;
  localparam int unsigned QW = FB + 4;

  typedef struct packed {
    logic [QW-1:0] quot;
    logic          err;
    int unsigned   lat;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [15:0]   total_i;
  logic [15:0]   inside_i;
  logic          busy_o;
  logic          done_o;
  logic [QW-1:0] quot_o;
  logic          err_o;

  int total;
  int bad;
  exp_t sb[$];

  pi_ratio_div #(.FRAC_BITS(FB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .total_i  (total_i),
    .inside_i (inside_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .quot_o   (quot_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] t, input logic [15:0] i);
    exp_t e;
    longint unsigned num, q, r;
    if (t == 16'd0 || i > t) begin
      e.quot = '1;
      e.err  = 1'b1;
      e.lat  = 1;
      return e;
    end
    num = longint'(i) << (FB + 2);
    q   = num / longint'(t);
    r   = num % longint'(t);
`ifdef PI_DIV_ROUND_EN
    if (2 * r >= longint'(t) && q != (64'd1 << QW) - 1) q = q + 1;
    e.lat = QW + 2;
`else
    e.lat = QW + 1;
`endif
    e.quot = QW'(q);
    e.err  = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; optionally poke a second start with new inputs at cycle poke_at.
  task automatic run_req(input logic [15:0] t, input logic [15:0] i, input int poke_at);
    exp_t e;
    int n;
    int extra;
    @(negedge clk);
    total_i = t; inside_i = i; start_i = 1'b1;
    sb.push_back(model(t, i));
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    check("busy_after_start", busy_o, 1);
    while (!done_o && n < 40) begin
      @(negedge clk);
      n++;
      if (start_i) start_i = 1'b0;
      if (n == poke_at) begin
        start_i = 1'b1; total_i = 16'd7; inside_i = 16'd2;
      end
    end
    start_i = 1'b0;
    e = sb.pop_front();
    check("done_seen", done_o, 1);
    check("latency", n, e.lat);
    check("quot", quot_o, e.quot);
    check("err", err_o, e.err);
    check("busy_at_done", busy_o, 0);
    extra = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    check("no_extra_done", extra, 0);
    check("quot_hold", quot_o, e.quot);
  endtask

  initial begin
    int cnt;
    logic [15:0] rt, ri;
    total = 0; bad = 0;
    rst_n = 1'b0; start_i = 1'b0; total_i = '0; inside_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_quot", quot_o, 0);
    check("rst_err", err_o, 0);
    rst_n = 1'b1;

    run_req(16'd1000, 16'd785, -1);
`ifdef PI_DIV_ROUND_EN
    check("headline_quot", quot_o, 12'h324);
`else
    check("headline_quot", quot_o, 12'h323);
`endif
    run_req(16'd500, 16'd500, -1);
    check("full_quot", quot_o, 12'h400);
    run_req(16'd1, 16'd0, -1);
    check("zero_quot", quot_o, 12'h000);
    run_req(16'd0, 16'd0, -1);
    run_req(16'd5, 16'd10, -1);
    run_req(16'd3, 16'd2, -1);
    check("err_cleared", err_o, 0);
    run_req(16'hFFFF, 16'hFFFE, -1);
    run_req(16'd7, 16'd3, -1);

    // Second start and changed inputs mid-division must be ignored.
    run_req(16'd1000, 16'd785, 3);

    for (int k = 0; k < 5; k++) begin
      rt = 16'($urandom_range(1, 65535));
      ri = 16'($urandom_range(0, int'(rt)));
      run_req(rt, ri, -1);
    end

    // Reset mid-division: outputs clear at once and no done follows.
    @(negedge clk);
    total_i = 16'd1000; inside_i = 16'd785; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_quot", quot_o, 0);
    check("arst_err", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_o) cnt++;
    end
    check("no_done_after_abort", cnt, 0);
    check("idle_after_abort", busy_o, 0);
    run_req(16'd1000, 16'd785, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
